// File: rtl/traffic_light_pkg.sv
// Shared phase codes, lamp encodings and direction codes for the intersection controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StNsClear  = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StEwClear  = 3'd5,
    StPedWalk  = 3'd6,
    StFlash    = 3'd7
  } phase_e;

  typedef enum logic {
    DirNs = 1'b0,
    DirEw = 1'b1
  } dir_e;

  // Lamp encoding {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Steady lamp pattern {ns, ew} shown in each phase.
  function automatic logic [5:0] lamps_of(phase_e p);
    logic [5:0] l;
    case (p)
      StNsGreen:  l = {LAMP_GRN, LAMP_RED};
      StNsYellow: l = {LAMP_YEL, LAMP_RED};
      StEwGreen:  l = {LAMP_RED, LAMP_GRN};
      StEwYellow: l = {LAMP_RED, LAMP_YEL};
      StFlash:    l = {LAMP_YEL, LAMP_YEL};
      default:    l = {LAMP_RED, LAMP_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Remaining-seconds counter: loads a phase duration, counts down on the 1 s strobe, flags expiry.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] light_t_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Never decrements below 1: reaching 1 with a tick is expiry, and the owner reloads.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt_q <= load_value_i;
    end else if (tick_i && (cnt_q > CNT_W'(1))) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign light_t_o = cnt_q;
  assign expire_o  = tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_light_intersection.sv
// Two-approach intersection controller with all-red clearance and night flashing mode.
// Pedestrian walk phase is built only when TL_PED_EN is defined.
module traffic_light_intersection
  import traffic_light_pkg::*;
#(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned PED_TIME    = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_p,
  input  logic             tick_1s,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic [CNT_W-1:0] light_t,
  output logic [2:0]       phase
);

  if (GREEN_TIME == 0 || (GREEN_TIME >> CNT_W) != 0 ||
      YELLOW_TIME == 0 || (YELLOW_TIME >> CNT_W) != 0 ||
      ALLRED_TIME == 0 || (ALLRED_TIME >> CNT_W) != 0 ||
      PED_TIME == 0 || (PED_TIME >> CNT_W) != 0) begin : g_bad_duration
    $fatal(1, "traffic_light_intersection: a phase duration is 0 or does not fit CNT_W");
  end

  function automatic logic [CNT_W-1:0] phase_dur(phase_e p);
    logic [CNT_W-1:0] d;
    case (p)
      StNsGreen, StEwGreen:   d = CNT_W'(GREEN_TIME);
      StNsYellow, StEwYellow: d = CNT_W'(YELLOW_TIME);
      StNsClear, StEwClear:   d = CNT_W'(ALLRED_TIME);
      StPedWalk:              d = CNT_W'(PED_TIME);
      default:                d = '0;
    endcase
    return d;
  endfunction

  phase_e           state_q, state_d;
  dir_e             next_dir_q, next_dir_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  logic             walk_q, walk_d;
  logic             load_c, load;
  logic [CNT_W-1:0] load_value_c, load_value;
  logic             expire;
  logic             enter_ped;
  logic             ped_pending;

  always_comb begin
    state_d      = state_q;
    next_dir_d   = next_dir_q;
    ns_d         = ns_q;
    ew_d         = ew_q;
    walk_d       = walk_q;
    load_c       = 1'b0;
    load_value_c = '0;
    enter_ped    = 1'b0;
    if (flash_mode) begin
      state_d      = StFlash;
      load_c       = 1'b1;
      load_value_c = '0;
      walk_d       = 1'b0;
      if (state_q != StFlash) begin
        ns_d = LAMP_YEL;
        ew_d = LAMP_YEL;
      end else if (tick_1s) begin
        ns_d = (ns_q == LAMP_YEL) ? LAMP_OFF : LAMP_YEL;
        ew_d = (ns_q == LAMP_YEL) ? LAMP_OFF : LAMP_YEL;
      end
    end else begin
      case (state_q)
        StNsGreen:  if (expire) state_d = StNsYellow;
        StNsYellow: begin
          if (expire) begin
            state_d    = StNsClear;
            next_dir_d = DirEw;
          end
        end
        StEwGreen:  if (expire) state_d = StEwYellow;
        StEwYellow: begin
          if (expire) begin
            state_d    = StEwClear;
            next_dir_d = DirNs;
          end
        end
        StNsClear, StEwClear, StPedWalk: begin
          // Clear states may divert to the walk; the walk itself always resumes the pending green.
          if (expire) begin
            if (state_q != StPedWalk && ped_pending) begin
              state_d = StPedWalk;
            end else begin
              state_d = (next_dir_q == DirNs) ? StNsGreen : StEwGreen;
            end
          end
        end
        default: begin
          // Leaving FLASH (or an unexpected code) restarts like reset.
          state_d    = StEwClear;
          next_dir_d = DirNs;
        end
      endcase
      if (state_d != state_q) begin
        load_c       = 1'b1;
        load_value_c = phase_dur(state_d);
      end
      {ns_d, ew_d} = lamps_of(state_d);
      walk_d       = (state_d == StPedWalk);
      enter_ped    = (state_d == StPedWalk) && (state_q != StPedWalk);
    end
  end

  assign load       = load_c || sys_rst_p;
  assign load_value = sys_rst_p ? CNT_W'(ALLRED_TIME) : load_value_c;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      state_q    <= StEwClear;
      next_dir_q <= DirNs;
      ns_q       <= LAMP_RED;
      ew_q       <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
    end
  end

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i       (sys_clk),
    .load_i      (load),
    .load_value_i(load_value),
    .tick_i      (tick_1s),
    .light_t_o   (light_t),
    .expire_o    (expire)
  );

`ifdef TL_PED_EN
  logic ped_pending_q, ped_pending_d;

  // Clearing on walk entry wins over a same-edge press, so one walk serves all earlier presses.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (flash_mode || enter_ped) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && state_q != StPedWalk && state_q != StFlash) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      ped_pending_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
    end
  end

  assign ped_pending = ped_pending_q;
  assign ped_walk    = walk_q;
`else
  logic unused_ped;
  assign unused_ped  = ped_req ^ walk_q ^ enter_ped;
  assign ped_pending = 1'b0;
  assign ped_walk    = 1'b0;
`endif

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed self-checking bench for traffic_light_intersection at default parameters.
module tb_traffic_light_intersection;
  import traffic_light_pkg::*;

  localparam int unsigned CW = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_p = 1'b1;
  logic          tick_1s = 1'b0;
  logic          ped_req = 1'b0;
  logic          flash_mode = 1'b0;
  logic [2:0]    ns_light, ew_light, phase;
  logic          ped_walk;
  logic [CW-1:0] light_t;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  traffic_light_intersection #(
    .CNT_W      (CW),
    .GREEN_TIME (10),
    .YELLOW_TIME(3),
    .ALLRED_TIME(2),
    .PED_TIME   (6)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_p (sys_rst_p),
    .tick_1s   (tick_1s),
    .ped_req   (ped_req),
    .flash_mode(flash_mode),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .light_t   (light_t),
    .phase     (phase)
  );

  wire [15:0] obs = {phase, light_t, ns_light, ew_light, ped_walk};

  function automatic logic [15:0] pk(logic [2:0] p, int t, logic [2:0] n, logic [2:0] e, logic w);
    return {p, 6'(t), n, e, w};
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // One second = one strobe cycle followed by three idle cycles.
  task automatic tick_once();
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic run_ticks(int n);
    repeat (n) tick_once();
  endtask

  task automatic test_reset();
    logic [15:0] e;
    sys_rst_p = 1'b1; tick_1s = 1'b1; flash_mode = 1'b1; ped_req = 1'b1;
    cyc();
    cyc();
    e = pk(StEwClear, 2, LAMP_RED, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", obs, e);
    end
    sys_rst_p = 1'b0; tick_1s = 1'b0; flash_mode = 1'b0; ped_req = 1'b0;
    cyc();
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_release: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_cycle();
    phase_e     sp[6] = '{StNsGreen, StNsYellow, StNsClear, StEwGreen, StEwYellow, StEwClear};
    int         st[6] = '{10, 3, 2, 10, 3, 2};
    logic [2:0] sn[6] = '{LAMP_GRN, LAMP_YEL, LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};
    logic [2:0] se[6] = '{LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN, LAMP_YEL, LAMP_RED};
    logic [15:0] e;
    tick_once();
    e = pk(StEwClear, 1, LAMP_RED, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL cycle_first_tick: got %h expected %h", obs, e);
    end
    for (int i = 0; i < 6; i++) begin
      for (int t = st[i]; t >= 1; t--) begin
        tick_once();
        e = pk(sp[i], t, sn[i], se[i], 1'b0);
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL cycle_phase%0d_t%0d: got %h expected %h", i, t, obs, e);
        end
      end
    end
    tick_once();
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL cycle_wrap: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_hold();
    logic [15:0] e;
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL hold_cycle%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_flash();
    logic [15:0] e;
    run_ticks(26);
    e = pk(StEwYellow, 2, LAMP_RED, LAMP_YEL, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL pre_flash: got %h expected %h", obs, e);
    end
    flash_mode = 1'b1;
`ifdef TL_PED_EN
    ped_req = 1'b1;
`endif
    cyc();
    e = pk(StFlash, 0, LAMP_YEL, LAMP_YEL, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL flash_entry: got %h expected %h", obs, e);
    end
    for (int i = 0; i < 4; i++) begin
      tick_once();
      e = (i % 2 == 0) ? pk(StFlash, 0, LAMP_OFF, LAMP_OFF, 1'b0)
                       : pk(StFlash, 0, LAMP_YEL, LAMP_YEL, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL flash_toggle%0d: got %h expected %h", i, obs, e);
      end
    end
    ped_req = 1'b0;
    flash_mode = 1'b0;
    cyc();
    e = pk(StEwClear, 2, LAMP_RED, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL flash_exit: got %h expected %h", obs, e);
    end
    run_ticks(2);
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL flash_to_ns_green: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    run_ticks(3);
    e = pk(StNsGreen, 7, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL pre_reset_mid: got %h expected %h", obs, e);
    end
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    sys_rst_p = 1'b1; tick_1s = 1'b1;
    cyc();
    sys_rst_p = 1'b0; tick_1s = 1'b0;
    e = pk(StEwClear, 2, LAMP_RED, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", obs, e);
    end
    run_ticks(2);
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_mid_ns_green: got %h expected %h", obs, e);
    end
    run_ticks(15);
    e = pk(StEwGreen, 10, LAMP_RED, LAMP_GRN, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_mid_no_walk: got %h expected %h", obs, e);
    end
  endtask

`ifdef TL_PED_EN
  task automatic test_ped();
    logic [15:0] e;
    run_ticks(18);
    e = pk(StNsGreen, 7, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_setup: got %h expected %h", obs, e);
    end
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    run_ticks(7);
    e = pk(StNsYellow, 3, LAMP_YEL, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_wait_yellow: got %h expected %h", obs, e);
    end
    run_ticks(5);
    e = pk(StPedWalk, 6, LAMP_RED, LAMP_RED, 1'b1);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_walk_entry: got %h expected %h", obs, e);
    end
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    for (int t = 5; t >= 1; t--) begin
      tick_once();
      e = pk(StPedWalk, t, LAMP_RED, LAMP_RED, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL ped_walk_t%0d: got %h expected %h", t, obs, e);
      end
    end
    tick_once();
    e = pk(StEwGreen, 10, LAMP_RED, LAMP_GRN, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_to_ew_green: got %h expected %h", obs, e);
    end
    run_ticks(15);
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_no_extra_walk: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    run_ticks(14);
    e = pk(StNsClear, 1, LAMP_RED, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL same_edge_setup: got %h expected %h", obs, e);
    end
    ped_req = 1'b1; tick_1s = 1'b1;
    cyc();
    ped_req = 1'b0; tick_1s = 1'b0;
    cyc(); cyc(); cyc();
    e = pk(StPedWalk, 6, LAMP_RED, LAMP_RED, 1'b1);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL same_edge_walk: got %h expected %h", obs, e);
    end
    run_ticks(21);
    e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL same_edge_pending_cleared: got %h expected %h", obs, e);
    end
  endtask
`else
  task automatic test_ped_ignored();
    logic [15:0] e;
    ped_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick_once();
      checks++;
      if (ped_walk !== 1'b0 || phase === 3'(StPedWalk)) begin
        errors++;
        $display("FAIL ped_ignored_tick%0d: got walk=%b phase=%0d expected walk=0 no PED_WALK",
                 i, ped_walk, phase);
      end
      if (i == 14) begin
        e = pk(StNsGreen, 10, LAMP_GRN, LAMP_RED, 1'b0);
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL ped_ignored_ns_green: got %h expected %h", obs, e);
        end
      end
    end
    ped_req = 1'b0;
    e = pk(StEwGreen, 10, LAMP_RED, LAMP_GRN, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL ped_ignored_ew_green: got %h expected %h", obs, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cycle();
    test_hold();
    test_flash();
    test_reset_mid();
`ifdef TL_PED_EN
    test_ped();
    test_back_to_back();
`else
    test_ped_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_intersection.md
Name: traffic_light_intersection

Overview:
Two-approach (NS/EW) intersection controller and the parametrised successor of the single-approach light FSM.
- Runs entirely on sys_clk; the 1 s time base enters as a one-cycle enable strobe, not as a second clock.
- Phase durations, counter width and all-red clearance are parametrised.
- Adds a latched pedestrian walk phase and a night flashing-yellow mode.
- Drives the lamp drivers and the remaining-time display of one intersection.

Parameters:
CNT_W, 6, width of the remaining-seconds counter light_t
GREEN_TIME, 10, green duration per approach, seconds (1..2^CNT_W-1)
YELLOW_TIME, 3, yellow duration, seconds (1..2^CNT_W-1)
ALLRED_TIME, 2, all-red clearance after each yellow, seconds (1..2^CNT_W-1)
PED_TIME, 6, pedestrian walk duration, seconds (1..2^CNT_W-1)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_p  in  1  synchronous active-high reset
tick_1s  in  1  one-sys_clk-cycle strobe, once per second
ped_req  in  1  pedestrian button, level, already synchronised
flash_mode  in  1  night mode request, level, already synchronised
ns_light  out  3  NS lamps {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark
ew_light  out  3  EW lamps, same encoding
ped_walk  out  1  walk signal, high only in PED_WALK
light_t  out  CNT_W  seconds remaining in current phase; 0 in FLASH
phase  out  3  current state code, from package

Behaviour:
- States: NS_GREEN, NS_YELLOW, NS_CLEAR, EW_GREEN, EW_YELLOW, EW_CLEAR, PED_WALK, FLASH.
- Sequence: NS_GREEN -> NS_YELLOW -> NS_CLEAR -> EW_GREEN -> EW_YELLOW -> EW_CLEAR -> NS_GREEN.
- Clear-state exit: if ped_pending=1, go to PED_WALK; PED_WALK then exits to the green that would otherwise have followed. A 1-bit next_dir register records that green.
- Lamps per state:
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - EW_GREEN and EW_YELLOW: mirrored.
  - *_CLEAR and PED_WALK: both red.
- Timing:
  - On entry to a state, light_t loads that state's duration.
  - On each cycle with tick_1s=1: if light_t==1, transition (next state and new duration load together); else light_t decrements by 1.
  - Cycles without tick_1s hold all state.
- Latency: everything registered. A tick sampled at edge n makes the update visible after edge n; outputs change only on that edge.
- Reset (sys_rst_p=1 at an edge):
  - state=EW_CLEAR, light_t=ALLRED_TIME, next_dir=NS.
  - ns_light=ew_light=100, ped_walk=0, ped_pending=0.
  - Reset overrides tick and flash_mode, and works the same mid-phase.
- Pedestrian request:
  - ped_req=1 sets ped_pending in any state except PED_WALK and FLASH; it is ignored in those two states.
  - ped_pending clears on the edge that enters PED_WALK; clear wins if ped_req is high on that edge.
  - Multiple presses before service give one walk.
- FLASH mode:
  - flash_mode=1 at any edge, not in reset: enter FLASH on that edge, regardless of tick. ped_pending clears, light_t=0, ns_light=ew_light=010.
  - While in FLASH, each tick_1s toggles both lamps between 010 and 000 together.
  - flash_mode=0 while in FLASH: exit to EW_CLEAR with light_t=ALLRED_TIME, next_dir=NS, both lamps 100.
- Priority at one edge: reset > flash_mode > tick-driven transition > decrement.
- Illegal state code: recover on the next edge as if reset.
- Width rule: light_t never wraps. Loads are zero-extended constants. Elaboration fails (generate-time check) if any duration is 0 or does not fit CNT_W.

Optional Feature:
Macro TL_PED_EN.
- Defined: pedestrian logic as above.
- Undefined: ped_pending is not generated, ped_req is ignored (port kept), ped_walk is tied 0, PED_WALK is unreachable, and clear states always go to the next green.

Decomposition:
- Package traffic_light_pkg: phase codes (3-bit, including PED_WALK and FLASH), lamp constants LAMP_RED/LAMP_YEL/LAMP_GRN/LAMP_OFF, direction codes.
- One sub-module, tl_phase_timer, owns light_t:
  - inputs: load, load_value, tick;
  - outputs: light_t and expire, where expire = tick & light_t==1.
- The top holds the FSM, ped latch and lamp decode.

Test Plan (default parameters, tick_1s every 4 cycles):
- Reset release, no inputs: 10 ticks NS 001/EW 100, then 3 ticks NS 010, then 2 ticks both 100, then EW green. Full cycle is 30 ticks. light_t counts 10..1 and reloads exactly on expiry.
- ped_req pulse during NS_GREEN with light_t=7: after NS_CLEAR, PED_WALK with ped_walk=1 and light_t 6..1, then EW_GREEN. A second press during PED_WALK produces no extra walk.
- flash_mode raised mid EW_YELLOW: next edge both lamps 010 and light_t=0, toggling 010/000 per tick. On drop: EW_CLEAR, light_t=2, then NS_GREEN.
- sys_rst_p asserted mid NS_GREEN with ped_pending=1: next edge EW_CLEAR, light_t=2, ped_pending=0, and no PED_WALK follows.
- tick_1s held low 100 cycles: all outputs stable. ped_req and tick on the same edge as entering PED_WALK: pending ends 0.
- Build without TL_PED_EN: ped_req ignored, ped_walk constant 0, cycle identical to the first scenario.
